// File: rtl/mrd_rdx_pkg.sv
// rtl/mrd_rdx_pkg.sv - shared types, defaults and rounding/saturation helper for the radix stage wrapper
package mrd_rdx_pkg;

  localparam int NLANE_DEF  = 5;
  localparam int W_ADDR_DEF = 8;
  localparam int W_BIDX_DEF = 3;
  localparam int W_CALC     = 64;

  typedef struct packed {
    logic [W_CALC-1:0] re;
    logic [W_CALC-1:0] im;
  } cplx_t;

  // Round-half-up arithmetic right shift, then clamp to a signed w_out-bit range.
  function automatic logic [W_CALC-1:0] sat_rnd_shift(
    input  logic signed [W_CALC-1:0] x,
    input  logic [3:0]               s,
    input  int                       w_out,
    output logic                     ovf
  );
    logic signed [W_CALC-1:0] half;
    logic signed [W_CALC-1:0] y;
    logic signed [W_CALC-1:0] hi;
    logic signed [W_CALC-1:0] lo;
    half = 1;
    if (s != 4'd0) begin
      half = half <<< (s - 4'd1);
      y    = (x + half) >>> s;
    end else begin
      y = x;
    end
    hi  = 1;
    hi  = (hi <<< (w_out - 1)) - 1;
    lo  = -hi - 1;
    ovf = (y > hi) || (y < lo);
    if (y > hi)      y = hi;
    else if (y < lo) y = lo;
    return y;
  endfunction

endpackage

// File: rtl/mrd_rdx_stage_align_dly.sv
// rtl/mrd_rdx_stage_align_dly.sv - fixed-depth delay line; the top RST_W bits are cleared on reset
module mrd_dly_line
  #(
    parameter int W     = 8,
    parameter int DEPTH = 1,
    parameter int RST_W = 0
  )
  (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
  );

  localparam logic [W-1:0] KEEP_MASK = {W{1'b1}} >> RST_W;

  logic [W-1:0] r_pipe [DEPTH];

  // Only the flag bits at the top are cleared; payload bits simply keep shifting.
  always_ff @(posedge i_clk) begin
    r_pipe[0] <= i_rst_n ? i_data : (i_data & KEEP_MASK);
    for (int i = 1; i < DEPTH; i++) begin
      r_pipe[i] <= i_rst_n ? r_pipe[i-1] : (r_pipe[i-1] & KEEP_MASK);
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/mrd_rdx_stage_align.sv
// rtl/mrd_rdx_stage_align.sv - radix stage wrapper: sideband alignment, round/saturate, framing, bypass
module mrd_rdx_stage_align
  import mrd_rdx_pkg::*;
  #(
    parameter int NLANE    = NLANE_DEF,
    parameter int W_IN     = 30,
    parameter int W_OUT    = 30,
    parameter int W_ADDR   = W_ADDR_DEF,
    parameter int W_BIDX   = W_BIDX_DEF,
    parameter int CORE_LAT = 6
  )
  (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [NLANE*W_IN-1:0]   in_real,
    input  logic [NLANE*W_IN-1:0]   in_imag,
    input  logic [NLANE*W_BIDX-1:0] in_bidx,
    input  logic [NLANE*W_ADDR-1:0] in_addr,
    input  logic [3:0]              cfg_shift,
    input  logic                    cfg_bypass,
    input  logic [15:0]             cfg_frame_len,
    output logic                    core_in_val,
    output logic [NLANE*W_IN-1:0]   core_in_re,
    output logic [NLANE*W_IN-1:0]   core_in_im,
    input  logic                    core_out_val,
    input  logic [NLANE*W_IN-1:0]   core_out_re,
    input  logic [NLANE*W_IN-1:0]   core_out_im,
    output logic                    out_valid,
    output logic [NLANE*W_OUT-1:0]  out_real,
    output logic [NLANE*W_OUT-1:0]  out_imag,
    output logic [NLANE*W_BIDX-1:0] out_bidx,
    output logic [NLANE*W_ADDR-1:0] out_addr,
    output logic                    frame_done,
    output logic                    ovf_sticky,
    output logic                    align_err
  );

  localparam int W_LB  = NLANE * W_BIDX;
  localparam int W_LA  = NLANE * W_ADDR;
  localparam int W_LD  = NLANE * W_IN;
  localparam int W_SB  = 7 + W_LB + W_LA;
  localparam int W_DAT = 2 * W_LD;

  logic [15:0] r_in_cnt;
  logic [3:0]  r_shift_lat;
  logic        r_bypass_lat;
  logic [15:0] r_flen_lat;

  logic        w_frame_start;
  logic [3:0]  w_shift_eff;
  logic        w_bypass_eff;
  logic [15:0] w_flen_eff;
  logic        w_in_last;

  // A beat that opens a frame runs with the settings it latches, not the stale ones.
  assign w_frame_start = (r_in_cnt == 16'd0);
  assign w_shift_eff   = w_frame_start ? cfg_shift     : r_shift_lat;
  assign w_bypass_eff  = w_frame_start ? cfg_bypass    : r_bypass_lat;
  assign w_flen_eff    = w_frame_start ? cfg_frame_len : r_flen_lat;
  assign w_in_last     = (w_flen_eff != 16'd0) && (r_in_cnt == w_flen_eff - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_cnt     <= 16'd0;
      r_shift_lat  <= 4'd0;
      r_bypass_lat <= 1'b0;
      r_flen_lat   <= 16'd0;
    end else if (in_valid) begin
      if (w_frame_start) begin
        r_shift_lat  <= cfg_shift;
        r_bypass_lat <= cfg_bypass;
        r_flen_lat   <= cfg_frame_len;
      end
      r_in_cnt <= (w_in_last || (w_flen_eff == 16'd0)) ? 16'd0 : r_in_cnt + 16'd1;
    end
  end

  assign core_in_val = in_valid & ~w_bypass_eff;
  assign core_in_re  = in_real;
  assign core_in_im  = in_imag;

  logic [W_SB-1:0]  w_sb_in;
  logic [W_SB-1:0]  w_sb_out;
  logic [W_DAT-1:0] w_byp_dat;

  // Valid and bypass sit at the top so the delay line clears exactly those two.
  assign w_sb_in = {in_valid, w_bypass_eff, in_valid & w_in_last, w_shift_eff, in_bidx, in_addr};

  mrd_dly_line #(.W(W_SB), .DEPTH(CORE_LAT), .RST_W(2)) u_sb_dly (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (w_sb_in),
    .o_data  (w_sb_out)
  );

  mrd_dly_line #(.W(W_DAT), .DEPTH(CORE_LAT), .RST_W(0)) u_byp_dly (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  ({in_real, in_imag}),
    .o_data  (w_byp_dat)
  );

  logic            w_tap_valid;
  logic            w_tap_bypass;
  logic            w_tap_last;
  logic [3:0]      w_tap_shift;
  logic [W_LB-1:0] w_tap_bidx;
  logic [W_LA-1:0] w_tap_addr;
  logic [W_LD-1:0] w_sel_re;
  logic [W_LD-1:0] w_sel_im;

  assign {w_tap_valid, w_tap_bypass, w_tap_last, w_tap_shift, w_tap_bidx, w_tap_addr} = w_sb_out;
  assign w_sel_re = w_tap_bypass ? w_byp_dat[W_DAT-1 -: W_LD] : core_out_re;
  assign w_sel_im = w_tap_bypass ? w_byp_dat[W_LD-1:0]        : core_out_im;

  cplx_t                  w_x;
  logic                   w_ovf_re;
  logic                   w_ovf_im;
  logic                   w_ovf_any;
  logic [NLANE*W_OUT-1:0] w_res_re;
  logic [NLANE*W_OUT-1:0] w_res_im;

  always_comb begin
    w_x       = '0;
    w_ovf_re  = 1'b0;
    w_ovf_im  = 1'b0;
    w_ovf_any = 1'b0;
    w_res_re  = '0;
    w_res_im  = '0;
    for (int l = 0; l < NLANE; l++) begin
      w_x.re = W_CALC'($signed(w_sel_re[l*W_IN +: W_IN]));
      w_x.im = W_CALC'($signed(w_sel_im[l*W_IN +: W_IN]));
      w_res_re[l*W_OUT +: W_OUT] = W_OUT'(sat_rnd_shift(w_x.re, w_tap_shift, W_OUT, w_ovf_re));
      w_res_im[l*W_OUT +: W_OUT] = W_OUT'(sat_rnd_shift(w_x.im, w_tap_shift, W_OUT, w_ovf_im));
      w_ovf_any = w_ovf_any | w_ovf_re | w_ovf_im;
    end
  end

  // The delayed sideband valid is the output strobe; the core's valid only feeds the alignment check.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_real   <= '0;
      out_imag   <= '0;
      out_bidx   <= '0;
      out_addr   <= '0;
      frame_done <= 1'b0;
      ovf_sticky <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      out_valid  <= w_tap_valid;
      frame_done <= w_tap_valid & w_tap_last;
      if (w_tap_valid) begin
        out_real <= w_res_re;
        out_imag <= w_res_im;
        out_bidx <= w_tap_bidx;
        out_addr <= w_tap_addr;
        if (w_ovf_any) ovf_sticky <= 1'b1;
      end
      if (!w_tap_bypass && (core_out_val != w_tap_valid)) align_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mrd_rdx_stage_align.sv
// tb/tb_mrd_rdx_stage_align.sv - randomized bench with a behavioural scoreboard for mrd_rdx_stage_align
module tb_mrd_rdx_stage_align;

  localparam int NL = 5, WI = 30, WO = 16, WA = 8, WB = 3, LAT = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, in_valid, cfg_bypass;
  logic [NL*WI-1:0]     in_real, in_imag;
  logic [NL*WB-1:0]     in_bidx;
  logic [NL*WA-1:0]     in_addr;
  logic [3:0]           cfg_shift;
  logic [15:0]          cfg_frame_len;
  logic                 core_in_val, core_out_val;
  logic [NL*WI-1:0]     core_in_re, core_in_im, core_out_re, core_out_im;
  logic                 out_valid, frame_done, ovf_sticky, align_err;
  logic [NL*WO-1:0]     out_real, out_imag;
  logic [NL*WB-1:0]     out_bidx;
  logic [NL*WA-1:0]     out_addr;

  mrd_rdx_stage_align #(.NLANE(NL), .W_IN(WI), .W_OUT(WO), .W_ADDR(WA), .W_BIDX(WB), .CORE_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
    .in_bidx(in_bidx), .in_addr(in_addr), .cfg_shift(cfg_shift), .cfg_bypass(cfg_bypass),
    .cfg_frame_len(cfg_frame_len), .core_in_val(core_in_val), .core_in_re(core_in_re),
    .core_in_im(core_in_im), .core_out_val(core_out_val), .core_out_re(core_out_re),
    .core_out_im(core_out_im), .out_valid(out_valid), .out_real(out_real), .out_imag(out_imag),
    .out_bidx(out_bidx), .out_addr(out_addr), .frame_done(frame_done), .ovf_sticky(ovf_sticky),
    .align_err(align_err)
  );

  // Core stub: echoes accepted data after LAT (or LAT+1) cycles; zero data when not fed.
  logic [NL*WI-1:0] st_re [LAT+1];
  logic [NL*WI-1:0] st_im [LAT+1];
  logic             st_val [LAT+1];
  bit               stub_slow = 1'b0;

  always @(posedge clk) begin
    st_val[0] <= rst_n & core_in_val;
    st_re[0]  <= core_in_val ? core_in_re : '0;
    st_im[0]  <= core_in_val ? core_in_im : '0;
    for (int i = 1; i <= LAT; i++) begin
      st_val[i] <= rst_n & st_val[i-1];
      st_re[i]  <= st_re[i-1];
      st_im[i]  <= st_im[i-1];
    end
  end

  assign core_out_val = stub_slow ? st_val[LAT] : st_val[LAT-1];
  assign core_out_re  = stub_slow ? st_re[LAT]  : st_re[LAT-1];
  assign core_out_im  = stub_slow ? st_im[LAT]  : st_im[LAT-1];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    longint           due;
    logic [NL*WO-1:0] re, im;
    logic [NL*WB-1:0] bidx;
    logic [NL*WA-1:0] addr;
    bit               fd, ovf;
  } exp_t;

  exp_t        q[$];
  exp_t        ce;
  longint      cyc = 0;
  bit          sb_en = 1'b1;
  int          m_cnt, m_flen, m_shift, ob_idx, fd_count;
  bit          m_ovf;
  logic [31:0] fd_beats;
  longint      b_re[NL], b_im[NL];
  int          b_bidx[NL], b_addr[NL];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint ref_out(input longint x, input int s, output bit clip);
    longint d, t, y, hi, lo;
    if (s == 0) y = x;
    else begin
      d = longint'(1) << s;
      t = x + d / 2;
      y = (t >= 0) ? t / d : -((-t + d - 1) / d);
    end
    hi = (longint'(1) << (WO - 1)) - 1;
    lo = -(longint'(1) << (WO - 1));
    clip = 1'b0;
    if (y > hi)      begin y = hi; clip = 1'b1; end
    else if (y < lo) begin y = lo; clip = 1'b1; end
    return y;
  endfunction

  always @(negedge clk) begin
    if (rst_n && sb_en) begin
      if (out_valid) begin
        ob_idx++;
        if (frame_done) begin
          fd_count++;
          if (ob_idx < 32) fd_beats = fd_beats | (32'd1 << ob_idx);
        end
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        ce = q.pop_front();
        chk("out_valid", out_valid, 1);
        chk("out_real", out_real, ce.re);
        chk("out_imag", out_imag, ce.im);
        chk("out_bidx", out_bidx, ce.bidx);
        chk("out_addr", out_addr, ce.addr);
        chk("frame_done", frame_done, ce.fd);
        chk("ovf_sticky", ovf_sticky, ce.ovf);
        chk("align_err", align_err, 0);
      end else begin
        chk("out_valid_idle", out_valid, 0);
        chk("frame_done_idle", frame_done, 0);
      end
    end
  end

  task automatic drive_beat(input int s, input int byp, input int fl);
    exp_t e;
    bit   c, last;
    @(posedge clk); #1;
    in_valid      = 1'b1;
    cfg_shift     = 4'(s);
    cfg_bypass    = byp[0];
    cfg_frame_len = 16'(fl);
    for (int l = 0; l < NL; l++) begin
      in_real[l*WI +: WI] = WI'(b_re[l]);
      in_imag[l*WI +: WI] = WI'(b_im[l]);
      in_bidx[l*WB +: WB] = WB'(b_bidx[l]);
      in_addr[l*WA +: WA] = WA'(b_addr[l]);
    end
    if (m_cnt == 0) begin
      m_shift = s;
      m_flen  = fl;
    end
    last  = (m_flen != 0) && (m_cnt == m_flen - 1);
    m_cnt = (m_flen == 0 || last) ? 0 : m_cnt + 1;
    for (int l = 0; l < NL; l++) begin
      e.re[l*WO +: WO]   = WO'(ref_out(b_re[l], m_shift, c));
      m_ovf              = m_ovf | c;
      e.im[l*WO +: WO]   = WO'(ref_out(b_im[l], m_shift, c));
      m_ovf              = m_ovf | c;
      e.bidx[l*WB +: WB] = WB'(b_bidx[l]);
      e.addr[l*WA +: WA] = WA'(b_addr[l]);
    end
    e.fd  = last;
    e.ovf = m_ovf;
    e.due = cyc + LAT + 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    m_cnt = 0; m_flen = 0; m_shift = 0; m_ovf = 1'b0;
    ob_idx = 0; fd_count = 0; fd_beats = '0;
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < LAT + 10 && q.size() > 0; i++) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_real"}, out_real, 0);
    chk({tag, "_imag"}, out_imag, 0);
    chk({tag, "_bidx"}, out_bidx, 0);
    chk({tag, "_addr"}, out_addr, 0);
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_ovf"}, ovf_sticky, 0);
    chk({tag, "_align"}, align_err, 0);
    chk({tag, "_core_val"}, core_in_val, 0);
  endtask

  task automatic clear_beat();
    for (int l = 0; l < NL; l++) begin
      b_re[l] = 0; b_im[l] = 0; b_bidx[l] = l; b_addr[l] = 16 * l + 3;
    end
  endtask

  function automatic longint rand_x();
    logic [WI-1:0] r;
    r = WI'($urandom);
    if ($urandom_range(0, 3) == 0) return longint'($signed(r));
    return longint'($urandom_range(0, 4000)) - 2000;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; cfg_shift = '0; cfg_bypass = 1'b0; cfg_frame_len = '0;
    in_real = '0; in_imag = '0; in_bidx = '0; in_addr = '0;
    do_reset(3);
    @(negedge clk);
    check_zero("reset");

    // Bypass single beat: exact latency and pass-through values.
    clear_beat();
    b_re[0] = 100; b_im[0] = -100; b_addr[0] = 'h12;
    drive_beat(0, 1, 0);
    idle(LAT);
    @(negedge clk);
    chk("lat_early", out_valid, 0);
    idle(1);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("byp_re0", out_real[WO-1:0], 16'd100);
    chk("byp_im0", out_imag[WO-1:0], 16'hFF9C);
    chk("byp_addr0", out_addr[WA-1:0], 8'h12);
    drain();

    // Rounding through the core path.
    do_reset(1);
    clear_beat();
    b_re[0] = 7; b_re[1] = -7; b_re[2] = 6; b_re[3] = -6; b_re[4] = 2;
    b_im[0] = -1; b_im[1] = 1; b_im[2] = 9; b_im[3] = -9; b_im[4] = 10;
    drive_beat(2, 0, 0);
    drain();
    chk("rnd_p7", out_real[0*WO +: WO], 16'd2);
    chk("rnd_m7", out_real[1*WO +: WO], 16'hFFFE);
    chk("rnd_p6", out_real[2*WO +: WO], 16'd2);

    // Saturation.
    do_reset(1);
    clear_beat();
    b_re[0] = 40000; b_re[1] = -40000; b_re[2] = 32767; b_re[3] = -32768; b_re[4] = 32768;
    drive_beat(0, 0, 0);
    drain();
    chk("sat_hi", out_real[0*WO +: WO], 16'h7FFF);
    chk("sat_lo", out_real[1*WO +: WO], 16'h8000);
    chk("sat_ovf", ovf_sticky, 1);

    // Framing: frame_len 4, shift change at beat 2 only applies from beat 5.
    do_reset(1);
    clear_beat();
    for (int b = 1; b <= 10; b++) begin
      b_re[0] = 100 + b; b_im[1] = -50 - b;
      drive_beat((b >= 2) ? 3 : 0, 0, 4);
    end
    drain();
    chk("fd_count", fd_count, 2);
    chk("fd_beats", fd_beats, (32'd1 << 4) | (32'd1 << 8));

    // Randomized traffic with mid-frame configuration churn.
    do_reset(1);
    for (int n = 0; n < 300; n++) begin
      for (int l = 0; l < NL; l++) begin
        b_re[l] = rand_x(); b_im[l] = rand_x();
        b_bidx[l] = $urandom_range(0, 7); b_addr[l] = $urandom_range(0, 255);
      end
      drive_beat($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    drain();

    // Core one cycle too slow: sticky alignment error.
    sb_en = 1'b0;
    stub_slow = 1'b1;
    do_reset(2);
    clear_beat();
    drive_beat(0, 0, 0);
    idle(LAT + 3);
    @(negedge clk);
    chk("align_set", align_err, 1);
    idle(10);
    @(negedge clk);
    chk("align_hold", align_err, 1);
    stub_slow = 1'b0;
    do_reset(2);
    @(negedge clk);
    chk("align_clr", align_err, 0);

    // One-cycle reset with three beats in flight.
    clear_beat();
    b_re[0] = 1234; b_addr[2] = 'h55;
    for (int b = 0; b < 3; b++) drive_beat(0, 0, 0);
    do_reset(1);
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      chk("flush_valid", out_valid, 0);
    end
    check_zero("flush");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
